// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the issue stage and the HI/LO multiply-divide unit.
// Carries operation request, MTHI/MTLO writes and the architectural HI/LO outputs.
// No internal state; pure signal grouping.
interface mul_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wr_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wr_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Latency: hi/lo and done update on the 33rd edge after start is sampled, for every operand.
// Backpressure: none; start and MTHI/MTLO writes are dropped while busy is high.
module mul_div_unit (
    input  logic          clk,
    input  logic          reset,
    mul_div_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic        is_div_q;
    logic        res_neg_q;
    logic        rem_neg_q;
    logic        b_zero_q;
    logic [31:0] a_q;
    logic [31:0] mag_b_q;
    logic [63:0] acc_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    // Operand magnitudes at capture; unsigned ops (op[0]=1) pass through unchanged.
    logic        op_signed;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    assign op_signed = ~bus.op[0];
    assign mag_a     = (op_signed && bus.a[31]) ? -bus.a : bus.a;
    assign mag_b     = (op_signed && bus.b[31]) ? -bus.b : bus.b;

    // Multiply step: conditional add of the multiplicand into the upper half, then shift right.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_b_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Divide step: shift {rem, dividend} left, trial-subtract divisor, restore on borrow.
    logic [32:0] rem_sh;
    logic [32:0] rem_diff;
    logic [63:0] div_next;
    assign rem_sh   = acc_q[63:31];
    assign rem_diff = rem_sh - {1'b0, mag_b_q};
    assign div_next = rem_diff[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                                   : {rem_diff[31:0], acc_q[30:0], 1'b1};

    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        prod   = res_neg_q ? -acc_q : acc_q;
        quo    = res_neg_q ? -acc_q[31:0] : acc_q[31:0];
        rem    = rem_neg_q ? -acc_q[63:32] : acc_q[63:32];
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div_q) begin
            // Divide by zero reports all-ones quotient and the untouched dividend.
            res_hi = b_zero_q ? a_q : rem;
            res_lo = b_zero_q ? 32'hFFFF_FFFF : quo;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (cnt_q == 5'd31) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= 5'd0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            b_zero_q  <= 1'b0;
            a_q       <= 32'd0;
            mag_b_q   <= 32'd0;
            acc_q     <= 64'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        cnt_q     <= 5'd0;
                        is_div_q  <= bus.op[1];
                        res_neg_q <= op_signed && (bus.a[31] ^ bus.b[31]);
                        rem_neg_q <= op_signed && bus.op[1] && bus.a[31];
                        b_zero_q  <= (bus.b == 32'd0);
                        a_q       <= bus.a;
                        mag_b_q   <= mag_b;
                        acc_q     <= {32'd0, mag_a};
                    end else begin
                        if (bus.hi_we) hi_q <= bus.wr_data;
                        if (bus.lo_we) lo_q <= bus.wr_data;
                    end
                end
                RUN: begin
                    acc_q <= is_div_q ? div_next : mul_next;
                    cnt_q <= cnt_q + 5'd1;
                end
                FINISH: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                end
                default: begin
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected {hi,lo} queued at issue, checked on done.
module tb_mul_div_unit;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mul_div_unit_if bus();

    mul_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    logic [63:0] sb[$];

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sbv;
        longint      p;
        logic [63:0] r;
        logic [31:0] q;
        logic [31:0] m;
        r = 64'd0;
        case (op)
            2'd0: begin
                sa  = $signed(a);
                sbv = $signed(b);
                p   = sa * sbv;
                r   = p;
            end
            2'd1: r = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else begin
                    q = $signed(a) / $signed(b);
                    m = $signed(a) % $signed(b);
                    r = {m, q};
                end
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    // Drives start for one edge, optionally queues the expected result, then scrambles operands.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [63:0] exp);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (push) sb.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fails++;
            $display("FAIL busy_after_start: got %b want 1", bus.busy);
        end
    endtask

    task automatic wait_result(input string name, input int inject_edge);
        bit          seen    = 0;
        int          seen_at = 0;
        bit          hold_ok = 1;
        bit          busy_ok = 1;
        bit          overlap = 0;
        logic [31:0] hi0;
        logic [31:0] lo0;
        logic [63:0] exp;
        hi0 = bus.hi;
        lo0 = bus.lo;
        for (int k = 1; k <= 40; k++) begin
            if (!seen) begin
                if (k == inject_edge) begin
                    bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd9; bus.b = 32'd3;
                    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wr_data = 32'hDEAD_BEEF;
                end
                @(posedge clk);
                @(negedge clk);
                if (k == inject_edge) begin
                    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
                end
                if (bus.busy === 1'b1 && bus.done === 1'b1) overlap = 1;
                if (bus.done === 1'b1) begin
                    seen    = 1;
                    seen_at = k;
                end else begin
                    if (bus.busy !== 1'b1) busy_ok = 0;
                    if (bus.hi !== hi0 || bus.lo !== lo0) hold_ok = 0;
                end
            end
        end
        n_checks++;
        if (!seen) begin
            n_fails++;
            $display("FAIL %s timeout: no done within 40 edges", name);
        end else begin
            n_checks++;
            if (seen_at !== 33) begin
                n_fails++;
                $display("FAIL %s latency: got %0d want 33", name, seen_at);
            end
            n_checks++;
            if (sb.size() == 0) begin
                n_fails++;
                $display("FAIL %s scoreboard: empty queue at done", name);
            end else begin
                exp = sb.pop_front();
                if ({bus.hi, bus.lo} !== exp) begin
                    n_fails++;
                    $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h",
                             name, bus.hi, bus.lo, exp[63:32], exp[31:0]);
                end
            end
        end
        n_checks++;
        if (!busy_ok || overlap) begin
            n_fails++;
            $display("FAIL %s busy: busy_ok=%b overlap=%b want 1/0", name, busy_ok, overlap);
        end
        n_checks++;
        if (!hold_ok) begin
            n_fails++;
            $display("FAIL %s hold: hi/lo changed before done (was %h/%h)", name, hi0, lo0);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fails++;
            $display("FAIL %s pulse: done=%b busy=%b want 0/0", name, bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
        bus.hi_we = 0; bus.lo_we = 0; bus.wr_data = 0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            n_fails++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h want all 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        reset = 1'b1;
    endtask

    task automatic test_spec_vectors();
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, {32'hFFFF_FFFE, 32'h0000_0001});
        wait_result("multu_max", 0);
        issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        wait_result("mult_neg", 0);
        issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        wait_result("div_neg", 0);
    endtask

    task automatic test_div_edge();
        issue(2'b11, 32'h0000_0005, 32'd0, 1, {32'h0000_0005, 32'hFFFF_FFFF});
        wait_result("divu_zero", 0);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, {32'h0000_0000, 32'h8000_0000});
        wait_result("div_overflow", 0);
        issue(2'b10, 32'hFFFF_FFF9, 32'd0, 1, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
        wait_result("div_zero_neg", 0);
    endtask

    task automatic test_busy_ignore();
        issue(2'b01, 32'd3, 32'd4, 1, {32'd0, 32'h0000_000C});
        wait_result("busy_ignore", 10);
    endtask

    task automatic test_mt_write();
        @(negedge clk);
        bus.hi_we = 1; bus.wr_data = 32'h1234_5678;
        @(posedge clk); @(negedge clk);
        bus.hi_we = 0;
        n_checks++;
        if (bus.hi !== 32'h1234_5678 || bus.lo !== 32'h0000_000C) begin
            n_fails++;
            $display("FAIL mthi: got hi=%h lo=%h want 12345678/0000000c", bus.hi, bus.lo);
        end
        bus.lo_we = 1; bus.wr_data = 32'h0BAD_F00D;
        @(posedge clk); @(negedge clk);
        bus.lo_we = 0;
        n_checks++;
        if (bus.hi !== 32'h1234_5678 || bus.lo !== 32'h0BAD_F00D) begin
            n_fails++;
            $display("FAIL mtlo: got hi=%h lo=%h want 12345678/0badf00d", bus.hi, bus.lo);
        end
        bus.hi_we = 1; bus.lo_we = 1; bus.wr_data = 32'h55AA_55AA;
        @(posedge clk); @(negedge clk);
        bus.hi_we = 0; bus.lo_we = 0;
        n_checks++;
        if (bus.hi !== 32'h55AA_55AA || bus.lo !== 32'h55AA_55AA) begin
            n_fails++;
            $display("FAIL mt_both: got hi=%h lo=%h want 55aa55aa", bus.hi, bus.lo);
        end
        bus.start = 1; bus.op = 2'b01; bus.a = 32'd2; bus.b = 32'd3;
        bus.hi_we = 1; bus.wr_data = 32'hAAAA_5555;
        sb.push_back({32'd0, 32'd6});
        @(posedge clk); @(negedge clk);
        bus.start = 0; bus.hi_we = 0;
        n_checks++;
        if (bus.hi !== 32'h55AA_55AA || bus.busy !== 1'b1) begin
            n_fails++;
            $display("FAIL start_wins: got hi=%h busy=%b want 55aa55aa/1", bus.hi, bus.busy);
        end
        wait_result("start_wins", 0);
    endtask

    task automatic test_async_reset();
        bit quiet = 1;
        issue(2'b01, 32'h0001_2345, 32'h0000_6789, 0, 64'd0);
        repeat (14) begin
            @(posedge clk); @(negedge clk);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            n_fails++;
            $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h want all 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) begin
            @(posedge clk); @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) quiet = 0;
        end
        n_checks++;
        if (!quiet) begin
            n_fails++;
            $display("FAIL reset_abort: done/busy/hi/lo disturbed after release, hi=%h lo=%h", bus.hi, bus.lo);
        end
        issue(2'b01, 32'd6, 32'd7, 1, {32'd0, 32'd42});
        wait_result("after_reset", 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] corners[6];
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
        for (int i = 0; i < 16; i++) begin
            op = 2'(i % 4);
            a  = (i < 8) ? corners[$urandom_range(0, 5)] : $urandom;
            b  = (i % 3 == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            issue(op, a, b, 1, model(op, a, b));
            wait_result($sformatf("rand%0d_op%0d", i, op), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_spec_vectors();
        test_div_edge();
        test_busy_ignore();
        test_mt_write();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
